// File: rtl/fp_pkg.sv
// Shared types, constants and classification helpers for the fp accumulator slice.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fp_pkg;

  // IEEE-754 binary32 field view
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  localparam logic [31:0] FP_ZERO    = 32'h00000000;
  localparam logic [31:0] FP_POS_INF = 32'h7F800000;
  localparam logic [31:0] FP_NEG_INF = 32'hFF800000;
  localparam logic [31:0] FP_NAN_DEF = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_ADD    = 2'd2,
    ST_DONE   = 2'd3
  } acc_state_t;

  // All-ones exponent with zero mantissa
  function automatic logic is_inf(input fp32_t v);
    return (v.exp == 8'hFF) && (v.man == 23'd0);
  endfunction

  // All-ones exponent with any mantissa bit set
  function automatic logic is_nan(input fp32_t v);
    return (v.exp == 8'hFF) && (v.man != 23'd0);
  endfunction

endpackage

// File: rtl/fp_accumulator_if.sv
// Bundle of the sample stream, adder operand/result path and block status for fp_accumulator.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready handshake on the sample stream; start/done are pulses.
// Optional: FP_ACC_FLAGS_EN adds the sticky flag_inf/flag_nan status bits.
//
// slave  : the accumulator's view (consumes start/samples/add_r, drives the rest)
// master : the parent's view (drives start/samples and the adder result)
interface fp_accumulator_if #(
  parameter int COUNT_W = 8
);

  logic               start;
  logic               in_valid;
  logic [31:0]        in_data;
  logic               in_ready;
  logic [31:0]        add_a;
  logic [31:0]        add_b;
  logic [31:0]        add_r;
  logic               busy;
  logic               done;
  logic [31:0]        sum_out;
  logic [COUNT_W-1:0] sum_count;
`ifdef FP_ACC_FLAGS_EN
  logic               flag_inf;
  logic               flag_nan;
`endif

  modport slave (
    input  start, in_valid, in_data, add_r,
    output in_ready, add_a, add_b, busy, done, sum_out, sum_count
`ifdef FP_ACC_FLAGS_EN
    , output flag_inf, flag_nan
`endif
  );

  modport master (
    output start, in_valid, in_data, add_r,
    input  in_ready, add_a, add_b, busy, done, sum_out, sum_count
`ifdef FP_ACC_FLAGS_EN
    , input flag_inf, flag_nan
`endif
  );

endinterface

// File: rtl/fp_accumulator.sv
// Accumulates MAX_COUNT binary32 samples through an external combinational adder.
// Latency: 2 cycles per sample; done pulses 2 cycles after the last sample is accepted.
// Backpressure: in_ready is high only in ACCEPT, so back-to-back valids stall one cycle.
// Optional: FP_ACC_FLAGS_EN adds sticky flag_inf/flag_nan outputs (cleared by start/reset).
//
// Ports: clk, rst_n (async active-low), acc (fp_accumulator_if.slave):
//   start, in_valid/in_data/in_ready, add_a/add_b -> adder, add_r <- adder,
//   busy, done, sum_out, sum_count [, flag_inf, flag_nan].
module fp_accumulator
  import fp_pkg::*;
#(
  parameter int MAX_COUNT = 16,
  parameter int COUNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  fp_accumulator_if.slave  acc
);

  localparam logic [COUNT_W-1:0] LAST_CNT = COUNT_W'(MAX_COUNT);

  acc_state_t         state;
  acc_state_t         state_nxt;
  fp32_t              add_a_q;
  fp32_t              add_b_q;
  fp32_t              sum_out_q;
  fp32_t              add_r;
  logic [COUNT_W-1:0] sum_count_q;
  logic [COUNT_W-1:0] count_inc;
  logic               busy_q;
  logic               done_q;
  logic               in_ready_c;

  assign add_r     = fp32_t'(acc.add_r);
  assign count_inc = sum_count_q + COUNT_W'(1);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (acc.start) state_nxt = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        in_ready_c = 1'b1;
        if (acc.in_valid) state_nxt = ST_ADD;
      end
      ST_ADD: begin
        state_nxt = (count_inc == LAST_CNT) ? ST_DONE : ST_ACCEPT;
      end
      ST_DONE: begin
        // start is deliberately not sampled here; a new block needs IDLE first
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // done is registered out of DONE so that it rises in the same cycle sum_out
  // carries the final value; the pulse lands as the FSM re-enters IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a_q     <= fp32_t'(FP_ZERO);
      add_b_q     <= fp32_t'(FP_ZERO);
      sum_out_q   <= fp32_t'(FP_ZERO);
      sum_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (acc.start) begin
            add_a_q     <= fp32_t'(FP_ZERO);
            sum_count_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        ST_ACCEPT: begin
          if (acc.in_valid) add_b_q <= fp32_t'(acc.in_data);
        end
        ST_ADD: begin
          // add_r has had a full cycle to settle from the registered operands
          add_a_q     <= add_r;
          sum_count_q <= count_inc;
        end
        ST_DONE: begin
          sum_out_q <= add_a_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef FP_ACC_FLAGS_EN
  logic flag_inf_q;
  logic flag_nan_q;

  // Sticky over the whole block; classification looks at every partial sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_inf_q <= 1'b0;
      flag_nan_q <= 1'b0;
    end else if (state == ST_IDLE && acc.start) begin
      flag_inf_q <= 1'b0;
      flag_nan_q <= 1'b0;
    end else if (state == ST_ADD) begin
      flag_inf_q <= flag_inf_q | is_inf(add_r);
      flag_nan_q <= flag_nan_q | is_nan(add_r);
    end
  end

  assign acc.flag_inf = flag_inf_q;
  assign acc.flag_nan = flag_nan_q;
`endif

  assign acc.in_ready  = in_ready_c;
  assign acc.add_a     = add_a_q;
  assign acc.add_b     = add_b_q;
  assign acc.busy      = busy_q;
  assign acc.done      = done_q;
  assign acc.sum_out   = sum_out_q;
  assign acc.sum_count = sum_count_q;

endmodule
